sim_supervisor: RTL
===================

// Module: sim_supervisor
// PURPOSE
//  Synthesizable simulation supervisor beside the cpu/simram pair in the bench top.
//  Replaces the fixed 16-bit cycle-count $finish with a parametrised cycle budget.
//  Adds a CPU reset sequencer and snooping of the CPU write bus for exit/console ports.
//  Reports pass/fail/timeout and buffers console bytes in a small FIFO.
// PARAMETERS
//  AWIDTH        16       write-address width snooped from cpu
//  DWIDTH        16       write-data width (32 for big cpu build)
//  TBITS         16       cycle-counter width; timeout at all-ones
//  RESET_CYCLES  4        cycles cpu_rst_n_o stays low after rst_n rises (>=1)
//  EXIT_ADDR     'hFFFF   write here ends the run; data = exit code
//  CONS_ADDR     'hFFFE   write here pushes wdata[7:0] into the console FIFO
//  CONS_DEPTH    8        console FIFO depth, power of two, >=2
// PORTS
//  clk           in   1       system clock
//  rst_n         in   1       async active-low reset
//  cpu_rst_n_o   out  1       sequenced active-low reset to the cpu
//  mem_waddr_i   in   AWIDTH  snooped cpu write address
//  mem_wdata_i   in   DWIDTH  snooped cpu write data
//  mem_wr_i      in   1       snooped cpu write strobe
//  done_o        out  1       run finished (exit or timeout); sticky
//  pass_o        out  1       done with exit code 0
//  timeout_o     out  1       done because the cycle budget expired
//  exit_code_o   out  DWIDTH  captured exit code
//  cycles_o      out  TBITS   cycles spent in RUN
//  cons_valid_o  out  1       console byte available
//  cons_data_o   out  8       console byte at FIFO head
//  cons_ready_i  in   1       consumer accepts byte
//  cons_drops_o  out  8       saturating count of bytes dropped on full FIFO
// BEHAVIOUR
//  Reset (async, rst_n=0): state RESET, cpu_rst_n_o=0, done/pass/timeout=0,
//   exit_code=0, cycles=0, FIFO empty, cons_valid_o=0, drops=0. Mid-run reset aborts all.
//  FSM RESET->RUN->DONE; no exit from DONE except rst_n.
//  RESET: seq counter counts RESET_CYCLES clocks after rst_n rises, then state=RUN and
//   cpu_rst_n_o=1 (registered, glitch-free).
//  RUN: cycles_o increments every clk. On mem_wr_i & waddr==EXIT_ADDR, next cycle:
//   DONE, exit_code_o=wdata, pass_o=(wdata==0), timeout_o=0.
//   On cycles_o==all-ones and no exit write, next cycle: DONE, timeout_o=1, pass_o=0.
//   Exit write and timeout in the same cycle: exit write wins.
//  DONE: cycles_o frozen; exit/console writes ignored; cpu_rst_n_o stays 1.
//  Writes in RESET state ignored. Writes to any other address ignored.
//  Console: mem_wr_i & waddr==CONS_ADDR in RUN pushes wdata[7:0].
//   Full FIFO: byte dropped, cons_drops_o += 1, saturating at 255.
//   Full and popping in the same cycle: push accepted (no drop).
//  cons_valid_o = !empty; pop on cons_valid_o & cons_ready_i; cons_data_o is head,
//   stable while valid & !ready. Drains in every state except RESET.
//   Zero-latency fall-through not required: push-to-valid latency is 1 cycle.
//  Pointers are log2(CONS_DEPTH)+1 bits and wrap naturally.
// CONFIGURATION
//  SIM_TRACE_EN defined: each popped console byte is $write'd as a char; on entry to DONE,
//   $display "PASS"/"FAIL code=%h"/"TIMEOUT" with cycles_o, then $finish after
//   the FIFO drains.
//  Undefined: no system tasks; block purely synthesizable; outputs identical either way.
// STRUCTURE
//  Package sim_pkg: typedef enum {SUP_RESET, SUP_RUN, SUP_DONE} sup_state_t;
//   default EXIT_ADDR/CONS_ADDR constants.
//  Sub-module sim_cons_fifo (8-bit sync FIFO, params DEPTH; push/full, pop/empty).
//   Drop counter and FSM stay in sim_supervisor.
// TESTING
//  1 rst_n low 3 clk then high -> cpu_rst_n_o rises exactly 4 clk later; cycles_o starts at 0.
//  2 RUN, write EXIT_ADDR data 0 -> next clk done=1 pass=1 timeout=0; later writes ignored.
//  3 write EXIT_ADDR data 'h0042 -> done=1 pass=0 exit_code_o=0042; cycles_o frozen.
//  4 TBITS=8, no exit -> done=1 timeout=1 at cycle 255; exit write same cycle -> pass path.
//  5 cons_ready_i=0, push 10 bytes 'A'..'J' -> valid, 8 held, drops=2; ready=1 drains A..H in order.
//  6 assert rst_n low mid-run with FIFO nonempty -> all outputs to reset values immediately.

Source files
------------

// File: rtl/sim_pkg.sv
// Shared types and default snoop addresses for the simulation supervisor.
package sim_pkg;

    typedef enum logic [1:0] {
        SUP_RESET,
        SUP_RUN,
        SUP_DONE
    } sup_state_t;

    localparam logic [15:0] DEF_EXIT_ADDR = 16'hFFFF;
    localparam logic [15:0] DEF_CONS_ADDR = 16'hFFFE;

endpackage

// File: rtl/sim_cons_fifo.sv
// 8-bit synchronous console FIFO; pointers carry one extra wrap bit.
// A push while full is taken only when a pop frees the head slot in the same cycle.
module sim_cons_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic [7:0] i_din,
    output logic       o_full,
    input  logic       i_pop,
    output logic [7:0] o_dout,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [7:0]  r_mem [DEPTH];
    logic        w_pop_ok;
    logic        w_push_ok;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_dout    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/sim_supervisor.sv
// Simulation supervisor: cpu reset sequencer, cycle budget, exit/console write snooping.
// Define SIM_TRACE_EN to echo console bytes, print the verdict and $finish once drained.
module sim_supervisor
    import sim_pkg::*;
#(
    parameter int                AWIDTH       = 16,
    parameter int                DWIDTH       = 16,
    parameter int                TBITS        = 16,
    parameter int                RESET_CYCLES = 4,
    parameter logic [AWIDTH-1:0] EXIT_ADDR    = AWIDTH'(DEF_EXIT_ADDR),
    parameter logic [AWIDTH-1:0] CONS_ADDR    = AWIDTH'(DEF_CONS_ADDR),
    parameter int                CONS_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              cpu_rst_n_o,
    input  logic [AWIDTH-1:0] mem_waddr_i,
    input  logic [DWIDTH-1:0] mem_wdata_i,
    input  logic              mem_wr_i,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [DWIDTH-1:0] exit_code_o,
    output logic [TBITS-1:0]  cycles_o,
    output logic              cons_valid_o,
    output logic [7:0]        cons_data_o,
    input  logic              cons_ready_i,
    output logic [7:0]        cons_drops_o
);
    localparam int SEQW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    sup_state_t        r_state, w_next;
    logic [SEQW-1:0]   r_seq;
    logic              r_cpu_rst_n;
    logic              r_done, r_pass, r_timeout;
    logic [DWIDTH-1:0] r_exit_code;
    logic [TBITS-1:0]  r_cycles;
    logic [7:0]        r_drops;

    logic w_seq_done, w_cyc_max, w_exit_wr, w_cons_wr;
    logic w_full, w_empty, w_pop, w_drop;
    logic [7:0] w_cons_data;

    assign w_seq_done = (r_seq == SEQW'(RESET_CYCLES - 1));
    assign w_cyc_max  = &r_cycles;
    assign w_exit_wr  = mem_wr_i && (mem_waddr_i == EXIT_ADDR) && (r_state == SUP_RUN);
    assign w_cons_wr  = mem_wr_i && (mem_waddr_i == CONS_ADDR) && (r_state == SUP_RUN);
    assign w_pop      = !w_empty && cons_ready_i && (r_state != SUP_RESET);
    assign w_drop     = w_cons_wr && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= SUP_RESET;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            SUP_RESET: if (w_seq_done) w_next = SUP_RUN;
            SUP_RUN:   if (w_exit_wr || w_cyc_max) w_next = SUP_DONE;
            default:   w_next = SUP_DONE;
        endcase
    end

    // Dedicated flop keeps the cpu reset glitch-free instead of decoding r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq       <= '0;
            r_cpu_rst_n <= 1'b0;
        end else if (r_state == SUP_RESET) begin
            if (w_seq_done) r_cpu_rst_n <= 1'b1;
            else            r_seq <= r_seq + 1'b1;
        end
    end

    // Counter holds at all-ones so a same-cycle exit write reports the saturated count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycles    <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_exit_code <= '0;
        end else if (r_state == SUP_RUN) begin
            if (!w_cyc_max) r_cycles <= r_cycles + 1'b1;
            if (w_exit_wr) begin
                r_done      <= 1'b1;
                r_exit_code <= mem_wdata_i;
                r_pass      <= (mem_wdata_i == '0);
            end else if (w_cyc_max) begin
                r_done    <= 1'b1;
                r_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_drops <= '0;
        else if (w_drop && r_drops != 8'hFF) r_drops <= r_drops + 1'b1;
    end

    sim_cons_fifo #(.DEPTH(CONS_DEPTH)) u_cons_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_cons_wr),
        .i_din   (mem_wdata_i[7:0]),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_dout  (w_cons_data),
        .o_empty (w_empty)
    );

    assign cpu_rst_n_o  = r_cpu_rst_n;
    assign done_o       = r_done;
    assign pass_o       = r_pass;
    assign timeout_o    = r_timeout;
    assign exit_code_o  = r_exit_code;
    assign cycles_o     = r_cycles;
    assign cons_valid_o = !w_empty && (r_state != SUP_RESET);
    assign cons_data_o  = w_cons_data;
    assign cons_drops_o = r_drops;

`ifdef SIM_TRACE_EN
    logic r_fin_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fin_pend <= 1'b0;
        end else begin
            if (w_pop) $write("%c", w_cons_data);
            if (r_state == SUP_DONE && !r_fin_pend) begin
                r_fin_pend <= 1'b1;
                if (r_timeout)   $display("TIMEOUT cycles=%0d", r_cycles);
                else if (r_pass) $display("PASS cycles=%0d", r_cycles);
                else             $display("FAIL code=%h cycles=%0d", r_exit_code, r_cycles);
            end
            if (r_fin_pend && w_empty) $finish;
        end
    end
`endif

endmodule
